// File: rtl/linescanner_capture_pkg.sv
// linescanner_capture_pkg: shared widths and FSM states for the linescanner pixel receiver
package linescanner_capture_pkg;
    localparam int PIXEL_WIDTH     = 8;
    localparam int WORD_WIDTH      = 32;
    localparam int PIXELS_PER_WORD = 4;
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
endpackage

// File: rtl/linescanner_word_fifo.sv
// linescanner_word_fifo: synchronous FIFO holding packed words with their end-of-line flag
module linescanner_word_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_rd, do_wr;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
    // Advance pointers; a write into a full FIFO succeeds when a read frees a slot on the same edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    // Storage array needs no reset: reads are masked to zero while empty
    always_ff @(posedge clk)
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/linescanner_pixel_line_receiver.sv
// linescanner_pixel_line_receiver: packs 8-bit linescanner pixels into 32-bit words per line
// Optional: define LINESCANNER_RX_DROP_COUNTER_EN to add the saturating dropped_words counter.
module linescanner_pixel_line_receiver
    import linescanner_capture_pkg::*;
#(
    parameter int LINE_LENGTH = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   main_clock_source,
    input  logic                   n_reset,
    input  logic                   enable,
    input  logic [PIXEL_WIDTH-1:0] pixel_data,
    input  logic                   pixel_captured,
    output logic [WORD_WIDTH-1:0]  word_data,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic                   word_last,
    output logic [15:0]            line_count,
    output logic                   busy,
    output logic                   overflow
`ifdef LINESCANNER_RX_DROP_COUNTER_EN
    ,
    output logic [15:0]            dropped_words
`endif
);
    state_t                                state;
    logic [15:0]                           pix_cnt;
    logic [WORD_WIDTH-PIXEL_WIDTH-1:0]     pack;
    logic [WORD_WIDTH:0]                   pend_word, rd_data;
    logic                                  pend, full, empty, last_pix, group_end, sample, quit, drop;

    assign quit       = state == CAPTURE && !enable;
    assign sample     = state == CAPTURE && enable && pixel_captured;
    assign last_pix   = pix_cnt == 16'(LINE_LENGTH - 1);
    assign group_end  = pix_cnt[1:0] == 2'(PIXELS_PER_WORD - 1);
    assign drop       = pend && full && !(word_valid && word_ready);
    assign word_valid = !empty;
    assign word_data  = rd_data[WORD_WIDTH-1:0];
    assign word_last  = rd_data[WORD_WIDTH];
    assign busy       = state != IDLE;

    // Capture FSM; DRAIN waits for both the FIFO and any word still in flight to it
    always_ff @(posedge main_clock_source or negedge n_reset)
        if (!n_reset) state <= IDLE;
        else state <= state == IDLE    ? (enable ? CAPTURE : IDLE) :
                      state == CAPTURE ? (enable ? CAPTURE : DRAIN) :
                      enable ? CAPTURE : (empty && !pend ? IDLE : DRAIN);

    // Pixel sampling and packing; leaving CAPTURE abandons the partial word and restarts the line
    always_ff @(posedge main_clock_source or negedge n_reset)
        if (!n_reset) begin
            pix_cnt    <= '0;
            pack       <= '0;
            pend       <= 1'b0;
            pend_word  <= '0;
            line_count <= '0;
        end else begin
            pend <= sample && group_end;
            if (quit) pix_cnt <= '0;
            else if (sample) begin
                pix_cnt <= last_pix ? '0 : pix_cnt + 16'd1;
                pack    <= {pixel_data, pack[WORD_WIDTH-PIXEL_WIDTH-1:PIXEL_WIDTH]};
                if (group_end) pend_word <= {last_pix, pixel_data, pack};
                if (last_pix) line_count <= line_count + 16'd1;
            end
        end

    // Sticky record of any word lost to a full FIFO
    always_ff @(posedge main_clock_source or negedge n_reset)
        if (!n_reset) overflow <= 1'b0;
        else overflow <= overflow | drop;

`ifdef LINESCANNER_RX_DROP_COUNTER_EN
    // Saturating count of words lost to a full FIFO
    always_ff @(posedge main_clock_source or negedge n_reset)
        if (!n_reset) dropped_words <= '0;
        else if (drop && dropped_words != 16'hFFFF) dropped_words <= dropped_words + 16'd1;
`endif

    linescanner_word_fifo #(
        .WIDTH (WORD_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (main_clock_source),
        .rst_n   (n_reset),
        .wr_en   (pend),
        .wr_data (pend_word),
        .rd_en   (word_ready),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );
endmodule

// File: doc/linescanner_pixel_line_receiver.md
LINESCANNER_PIXEL_LINE_RECEIVER -- requirements
Module: linescanner_pixel_line_receiver

Interface
REQ-001 SHALL have parameter LINE_LENGTH, default 1024, pixels per line; multiple of 4, range 4..65532.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output word FIFO depth; power of 2, at least 2.
REQ-003 SHALL have port main_clock_source, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port n_reset, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port enable, input, 1, capture enable from the system.
REQ-006 SHALL have port pixel_data, input, 8, pixel value from the linescanner.
REQ-007 SHALL have port pixel_captured, input, 1, one-cycle strobe marking pixel_data as valid.
REQ-008 SHALL have port word_data, output, 32, four packed pixels.
REQ-009 SHALL have port word_valid, output, 1, word_data is valid.
REQ-010 SHALL have port word_ready, input, 1, consumer accepts the word.
REQ-011 SHALL have port word_last, output, 1, the word is the final word of a line.
REQ-012 SHALL have port line_count, output, 16, number of completed lines (wrapping).
REQ-013 SHALL have port busy, output, 1, high when not IDLE.
REQ-014 SHALL have port overflow, output, 1, sticky flag for a word dropped because the FIFO was full.

Function
REQ-015 SHALL implement FSM IDLE/CAPTURE/DRAIN: IDLE->CAPTURE when enable=1; CAPTURE->DRAIN when enable=0; DRAIN->IDLE when FIFO empty; DRAIN->CAPTURE when enable=1.
REQ-016 SHALL sample pixel_data only in CAPTURE at an edge where pixel_captured=1, and ignore strobes in IDLE and DRAIN.
REQ-017 SHALL pack pixels little-endian: 1st pixel of the group in [7:0], 4th in [31:24].
REQ-018 SHALL write the completed word into the FIFO at the edge after the 4th pixel is sampled, so word_valid rises 2 cycles after the 4th strobe cycle when the FIFO was empty.
REQ-019 SHALL count pixels per line 0..LINE_LENGTH-1; pixel LINE_LENGTH-1 completes a line, sets word_last on that word, increments line_count, and the counter wraps to 0.
REQ-020 SHALL implement a valid/ready transfer on an edge with word_valid=1 and word_ready=1; word_data and word_last SHALL hold stable while word_valid=1 and word_ready=0.
REQ-021 SHALL write the FIFO on the same edge it is read when full, without loss (simultaneous read and write).
REQ-022 SHALL drop a word completed while the FIFO is full and no read occurs on that edge; set overflow; keep the pixel counter advancing; still increment line_count if the dropped word was the last of its line.
REQ-023 SHALL, when enable falls mid-line, discard the partial word and reset the pixel counter to 0, leave line_count unchanged, and still deliver the FIFO contents in DRAIN.
REQ-024 SHALL wrap line_count from 0xFFFF to 0x0000.

Reset
REQ-025 SHALL, on n_reset=0, drive state IDLE, word_valid=0, word_last=0, word_data=0, line_count=0, busy=0, overflow=0, an empty FIFO and a pixel counter of 0, all immediately and independent of the clock.
REQ-026 SHALL discard FIFO contents and any partial word on reset mid-operation, with the first line after release starting at pixel 0.
REQ-027 SHALL clear overflow only by reset.

Configuration
REQ-028 SHALL, with LINESCANNER_RX_DROP_COUNTER_EN defined, add output dropped_words[15:0] that resets to 0, increments once per dropped word, and saturates at 0xFFFF.
REQ-029 SHALL, without LINESCANNER_RX_DROP_COUNTER_EN, omit the dropped_words port and counter, leaving all other behaviour identical.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, CAPTURE, DRAIN), PIXEL_WIDTH=8, WORD_WIDTH=32 and PIXELS_PER_WORD=4 in package linescanner_capture_pkg.
REQ-031 SHALL implement the output buffer as sub-module linescanner_word_fifo: synchronous FIFO, width 33 (data plus last), depth FIFO_DEPTH, full/empty flags, same clock and reset.

Verification
REQ-032 SHALL test LINE_LENGTH=8 with a strobe every 2nd cycle carrying pixels 0x01..0x08 and word_ready=1 -> words 0x04030201 (last=0) then 0x08070605 (last=1), line_count=1.
REQ-033 SHALL test latency: single group 0xAA,0xBB,0xCC,0xDD on consecutive strobes with the FIFO empty -> word_valid high 2 cycles after the 0xDD strobe with 0xDDCCBBAA.
REQ-034 SHALL test backpressure: word_ready=0 while FIFO_DEPTH+1 words complete -> first FIFO_DEPTH words delivered intact after ready, one dropped, overflow=1, dropped_words=1 (macro on).
REQ-035 SHALL test enable dropped after 6 of 8 pixels, then re-enabled -> one word delivered, partial word discarded, busy low after drain, next line starts at pixel 0, line_count unchanged.
REQ-036 SHALL test n_reset pulsed low mid-line with 2 words queued -> outputs at reset values within the reset cycle, no stale word after release.
REQ-037 SHALL test line_count preloaded near wrap by running 0x10000 lines of LINE_LENGTH=4 -> line_count returns to 0.
